// File: rtl/serial_mem_responder.sv
// -----------------------------------------------------------------------------
// serial_mem_responder
//
// Byte-stream command responder bridging a host byte link to a simple 32-bit
// word memory port.
//
// Commands (all multi-byte fields are LSB first):
//    'W' (0x57) a0 a1 a2 a3 d0 d1 d2 d3   -> memory write, reply '.' (0x2E)
//    'R' (0x52) a0 a1 a2 a3               -> memory read, reply 4 data bytes
//    any other first byte                 -> reply '?' (0x3F)
//
// A partial command idle for TIMEOUT cycles is silently abandoned.
//
// Ports
//    clock       in   single clock, rising edge
//    reset_n     in   asynchronous active-low reset
//    rx_valid    in   host byte present
//    rx_data     in   host byte
//    rx_ready    out  responder accepts rx_data this cycle
//    tx_valid    out  response byte present
//    tx_data     out  response byte
//    tx_ready    in   downstream takes tx_data this cycle
//    mem_valid   out  memory request pending
//    mem_ready   in   memory accepts the request
//    mem_write   out  1 = write, 0 = read
//    mem_addr    out  word address
//    mem_wdata   out  write data
//    mem_rvalid  in   read data return strobe
//    mem_rdata   in   read data
//    state       out  current FSM state encoding (for LEDs)
// -----------------------------------------------------------------------------
module serial_mem_responder #(
   parameter int TIMEOUT = 1_000_000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [3:0]  state
);

   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;
   localparam logic [7:0] RSP_OK   = 8'h2E;
   localparam logic [7:0] RSP_BAD  = 8'h3F;

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      ADDR  = 4'd1,
      DATA  = 4'd2,
      MREQ  = 4'd3,
      MWAIT = 4'd4,
      RESP  = 4'd5
   } state_t;

   state_t          state_r;
   logic            rx_ready_r;
   logic            tx_valid_r;
   logic [7:0]      tx_data_r;
   logic            mem_valid_r;
   logic            mem_write_r;
   logic [31:0]     mem_addr_r;
   logic [31:0]     mem_wdata_r;
   logic [1:0]      byte_idx_r;
   logic [CW-1:0]   timeout_cnt_r;
   logic [31:0]     resp_r;       // response bytes still to send, next byte in [7:0]
   logic [2:0]      resp_len_r;   // number of response bytes still to send

   logic            rx_fire_s;
   logic            tx_fire_s;
   logic            mem_fire_s;

   // Handshake qualifiers: every output used here is a register, so these are
   // clean functions of current state and the partner's inputs.
   assign rx_fire_s  = rx_valid & rx_ready_r;
   assign tx_fire_s  = tx_valid_r & tx_ready;
   assign mem_fire_s = mem_valid_r & mem_ready;

   // Command FSM with all datapath and handshake outputs registered.
   // Outputs are updated on the same edge as the state change so that
   // rx_ready / tx_valid / mem_valid are already correct in the first cycle
   // of the destination state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= IDLE;
         rx_ready_r    <= 1'b0;
         tx_valid_r    <= 1'b0;
         tx_data_r     <= 8'h00;
         mem_valid_r   <= 1'b0;
         mem_write_r   <= 1'b0;
         mem_addr_r    <= 32'h0000_0000;
         mem_wdata_r   <= 32'h0000_0000;
         byte_idx_r    <= 2'd0;
         timeout_cnt_r <= '0;
         resp_r        <= 32'h0000_0000;
         resp_len_r    <= 3'd0;
      end else begin
         case (state_r)
            IDLE: begin
               // rx_ready is 0 only in the first cycle after reset release.
               rx_ready_r    <= 1'b1;
               timeout_cnt_r <= '0;
               if (rx_fire_s) begin
                  if ((rx_data == OP_WRITE) || (rx_data == OP_READ)) begin
                     mem_write_r <= (rx_data == OP_WRITE);
                     byte_idx_r  <= 2'd0;
                     state_r     <= ADDR;
                  end else begin
                     resp_r     <= {24'h00_0000, RSP_BAD};
                     tx_data_r  <= RSP_BAD;
                     resp_len_r <= 3'd1;
                     tx_valid_r <= 1'b1;
                     rx_ready_r <= 1'b0;
                     state_r    <= RESP;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end

            ADDR: begin
               if (rx_fire_s) begin
                  // A byte arriving on the timeout cycle still counts.
                  mem_addr_r[{byte_idx_r, 3'b000} +: 8] <= rx_data;
                  timeout_cnt_r <= '0;
                  if (byte_idx_r == 2'd3) begin
                     byte_idx_r <= 2'd0;
                     if (mem_write_r) begin
                        state_r <= DATA;
                     end else begin
                        rx_ready_r  <= 1'b0;
                        mem_valid_r <= 1'b1;
                        state_r     <= MREQ;
                     end
                  end else begin
                     byte_idx_r <= byte_idx_r + 2'd1;
                  end
               end else if (timeout_cnt_r == CNT_LIMIT) begin
                  // Abandon the partial command silently.
                  byte_idx_r    <= 2'd0;
                  timeout_cnt_r <= '0;
                  state_r       <= IDLE;
               end else if (timeout_cnt_r != CNT_MAX) begin
                  timeout_cnt_r <= timeout_cnt_r + {{(CW-1){1'b0}}, 1'b1};
               end else begin
                  timeout_cnt_r <= timeout_cnt_r;
               end
            end

            DATA: begin
               if (rx_fire_s) begin
                  mem_wdata_r[{byte_idx_r, 3'b000} +: 8] <= rx_data;
                  timeout_cnt_r <= '0;
                  if (byte_idx_r == 2'd3) begin
                     byte_idx_r  <= 2'd0;
                     rx_ready_r  <= 1'b0;
                     mem_valid_r <= 1'b1;
                     state_r     <= MREQ;
                  end else begin
                     byte_idx_r <= byte_idx_r + 2'd1;
                  end
               end else if (timeout_cnt_r == CNT_LIMIT) begin
                  byte_idx_r    <= 2'd0;
                  timeout_cnt_r <= '0;
                  state_r       <= IDLE;
               end else if (timeout_cnt_r != CNT_MAX) begin
                  timeout_cnt_r <= timeout_cnt_r + {{(CW-1){1'b0}}, 1'b1};
               end else begin
                  timeout_cnt_r <= timeout_cnt_r;
               end
            end

            MREQ: begin
               timeout_cnt_r <= '0;
               if (mem_fire_s) begin
                  mem_valid_r <= 1'b0;
                  if (mem_write_r) begin
                     resp_r     <= {24'h00_0000, RSP_OK};
                     tx_data_r  <= RSP_OK;
                     resp_len_r <= 3'd1;
                     tx_valid_r <= 1'b1;
                     state_r    <= RESP;
                  end else if (mem_rvalid) begin
                     // Zero-latency memory: data returns with the handshake.
                     resp_r     <= mem_rdata;
                     tx_data_r  <= mem_rdata[7:0];
                     resp_len_r <= 3'd4;
                     tx_valid_r <= 1'b1;
                     state_r    <= RESP;
                  end else begin
                     state_r <= MWAIT;
                  end
               end else begin
                  state_r <= MREQ;
               end
            end

            MWAIT: begin
               // No timeout here: the memory is trusted to answer eventually.
               if (mem_rvalid) begin
                  resp_r     <= mem_rdata;
                  tx_data_r  <= mem_rdata[7:0];
                  resp_len_r <= 3'd4;
                  tx_valid_r <= 1'b1;
                  state_r    <= RESP;
               end else begin
                  state_r <= MWAIT;
               end
            end

            RESP: begin
               if (tx_fire_s) begin
                  if (resp_len_r == 3'd1) begin
                     tx_valid_r <= 1'b0;
                     resp_len_r <= 3'd0;
                     rx_ready_r <= 1'b1;
                     state_r    <= IDLE;
                  end else begin
                     resp_r     <= {8'h00, resp_r[31:8]};
                     tx_data_r  <= resp_r[15:8];
                     resp_len_r <= resp_len_r - 3'd1;
                  end
               end else begin
                  state_r <= RESP;
               end
            end

            default: begin
               // Unreachable encodings fall back to a clean idle.
               rx_ready_r    <= 1'b1;
               tx_valid_r    <= 1'b0;
               mem_valid_r   <= 1'b0;
               byte_idx_r    <= 2'd0;
               timeout_cnt_r <= '0;
               resp_len_r    <= 3'd0;
               state_r       <= IDLE;
            end
         endcase
      end
   end

   assign rx_ready  = rx_ready_r;
   assign tx_valid  = tx_valid_r;
   assign tx_data   = tx_data_r;
   assign mem_valid = mem_valid_r;
   assign mem_write = mem_write_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign state     = state_r;

endmodule

// File: tb/tb_serial_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_serial_mem_responder
//
// Directed bench for serial_mem_responder (TIMEOUT = 16). Inputs are driven
// and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_serial_mem_responder;

   logic        clock      = 1'b0;
   logic        reset_n    = 1'b0;
   logic        rx_valid   = 1'b0;
   logic [7:0]  rx_data    = 8'h00;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready   = 1'b0;
   logic        mem_valid;
   logic        mem_ready  = 1'b0;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata  = 32'h0000_0000;
   logic [3:0]  state;

   int vectors     = 0;
   int miscompares = 0;

   // memory handshake monitor
   int          hs_count   = 0;
   logic        last_write = 1'b0;
   logic [31:0] last_addr  = 32'h0;
   logic [31:0] last_wdata = 32'h0;

   serial_mem_responder #(.TIMEOUT(16)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .state      (state)
   );

   always #5 clock = ~clock;

   // record every accepted memory request
   always @(posedge clock) begin
      if (mem_valid && mem_ready) begin
         hs_count   <= hs_count + 1;
         last_write <= mem_write;
         last_addr  <= mem_addr;
         last_wdata <= mem_wdata;
      end
   end

   // give a byte to the DUT; called and returns on a falling edge
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && n < 200) begin
         @(negedge clock);
         n++;
      end
      vectors++;
      if (n >= 200) begin
         miscompares++;
         $display("FAIL send_byte_%02h: rx_ready stayed %0b, required 1", b, rx_ready);
      end
      @(negedge clock);
      rx_valid = 1'b0;
   endtask

   // take one response byte and compare it
   task automatic recv_byte(input logic [7:0] exp, input string name);
      int n = 0;
      tx_ready = 1'b1;
      while (!tx_valid && n < 200) begin
         @(negedge clock);
         n++;
      end
      vectors++;
      if (tx_valid !== 1'b1 || tx_data !== exp) begin
         miscompares++;
         $display("FAIL %s: tx_valid=%0b tx_data=%02h, required tx_valid=1 tx_data=%02h",
                  name, tx_valid, tx_data, exp);
      end
      @(negedge clock);
      tx_ready = 1'b0;
   endtask

   // full read of address 0x10 returning 0x12345678 two cycles after handshake
   task automatic read_cmd(input string tag);
      mem_ready = 1'b1;
      send_byte(8'h52);
      send_byte(8'h10);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      vectors++;
      if (mem_valid !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h0000_0010) begin
         miscompares++;
         $display("FAIL %s_mreq: valid=%0b write=%0b addr=%08h, required 1 0 00000010",
                  tag, mem_valid, mem_write, mem_addr);
      end
      @(negedge clock);
      vectors++;
      if (state !== 4'd4 || mem_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_mwait: state=%0d mem_valid=%0b, required 4 0", tag, state, mem_valid);
      end
      @(negedge clock);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1234_5678;
      @(negedge clock);
      mem_rvalid = 1'b0;
      recv_byte(8'h78, {tag, "_b0"});
      recv_byte(8'h56, {tag, "_b1"});
      recv_byte(8'h34, {tag, "_b2"});
      recv_byte(8'h12, {tag, "_b3"});
      vectors++;
      if (state !== 4'd0 || tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_end: state=%0d tx_valid=%0b rx_ready=%0b, required 0 0 1",
                  tag, state, tx_valid, rx_ready);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      vectors++;
      if ({rx_ready, tx_valid, mem_valid, mem_write, tx_data, state} !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_ctrl: rx_ready=%0b tx_valid=%0b mem_valid=%0b mem_write=%0b tx_data=%02h state=%0d, required all 0",
                  rx_ready, tx_valid, mem_valid, mem_write, tx_data, state);
      end
      vectors++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_data: addr=%08h wdata=%08h, required 0 0", mem_addr, mem_wdata);
      end
      reset_n = 1'b1;
      @(negedge clock);
      vectors++;
      if (rx_ready !== 1'b1 || state !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_release: rx_ready=%0b state=%0d, required 1 0", rx_ready, state);
      end
   endtask

   task automatic test_write();
      int hs0 = hs_count;
      mem_ready = 1'b1;
      send_byte(8'h57);
      send_byte(8'h10);
      vectors++;
      if (state !== 4'd1) begin
         miscompares++;
         $display("FAIL write_addr_state: state=%0d, required 1", state);
      end
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      vectors++;
      if (state !== 4'd2 || rx_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL write_data_state: state=%0d rx_ready=%0b, required 2 1", state, rx_ready);
      end
      send_byte(8'hEF);
      send_byte(8'hBE);
      send_byte(8'hAD);
      send_byte(8'hDE);
      vectors++;
      if (mem_valid !== 1'b1 || mem_write !== 1'b1 || rx_ready !== 1'b0 || state !== 4'd3) begin
         miscompares++;
         $display("FAIL write_mreq: valid=%0b write=%0b rx_ready=%0b state=%0d, required 1 1 0 3",
                  mem_valid, mem_write, rx_ready, state);
      end
      recv_byte(8'h2E, "write_resp");
      vectors++;
      if (hs_count - hs0 !== 1 || last_write !== 1'b1 || last_addr !== 32'h0000_0010 ||
          last_wdata !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL write_mem: count=%0d write=%0b addr=%08h wdata=%08h, required 1 1 00000010 deadbeef",
                  hs_count - hs0, last_write, last_addr, last_wdata);
      end
      vectors++;
      if (state !== 4'd0 || tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL write_end: state=%0d tx_valid=%0b rx_ready=%0b, required 0 0 1",
                  state, tx_valid, rx_ready);
      end
   endtask

   task automatic test_read();
      read_cmd("read");
   endtask

   task automatic test_unknown();
      send_byte(8'h41);
      recv_byte(8'h3F, "unknown_resp");
      vectors++;
      if (rx_ready !== 1'b1 || state !== 4'd0) begin
         miscompares++;
         $display("FAIL unknown_ready: rx_ready=%0b state=%0d, required 1 0", rx_ready, state);
      end
      read_cmd("after_unknown");
   endtask

   task automatic test_timeout();
      int hs0 = hs_count;
      send_byte(8'h57);
      send_byte(8'h10);
      repeat (15) @(negedge clock);
      vectors++;
      if (state !== 4'd1) begin
         miscompares++;
         $display("FAIL timeout_early: state=%0d, required 1", state);
      end
      @(negedge clock);
      vectors++;
      if (state !== 4'd0 || tx_valid !== 1'b0 || mem_valid !== 1'b0 || hs_count !== hs0) begin
         miscompares++;
         $display("FAIL timeout_abort: state=%0d tx_valid=%0b mem_valid=%0b reqs=%0d, required 0 0 0 0",
                  state, tx_valid, mem_valid, hs_count - hs0);
      end
      read_cmd("after_timeout");

      // byte arriving on the final timeout cycle wins
      hs0 = hs_count;
      send_byte(8'h57);
      repeat (15) @(negedge clock);
      send_byte(8'h20);
      vectors++;
      if (state !== 4'd1) begin
         miscompares++;
         $display("FAIL timeout_edge_byte: state=%0d, required 1", state);
      end
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h44);
      send_byte(8'h33);
      send_byte(8'h22);
      send_byte(8'h11);
      recv_byte(8'h2E, "timeout_edge_resp");
      vectors++;
      if (hs_count - hs0 !== 1 || last_addr !== 32'h0000_0020 || last_wdata !== 32'h1122_3344) begin
         miscompares++;
         $display("FAIL timeout_edge_mem: count=%0d addr=%08h wdata=%08h, required 1 00000020 11223344",
                  hs_count - hs0, last_addr, last_wdata);
      end
   endtask

   task automatic test_backpressure();
      int err = 0;
      mem_ready = 1'b1;
      send_byte(8'h52);
      send_byte(8'h10);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      @(negedge clock);
      @(negedge clock);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1234_5678;
      @(negedge clock);
      mem_rvalid = 1'b0;
      // new host byte waits during the stalled response
      rx_valid = 1'b1;
      rx_data  = 8'h41;
      tx_ready = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (tx_valid !== 1'b1 || tx_data !== 8'h78 || rx_ready !== 1'b0 || state !== 4'd5)
            err++;
         @(negedge clock);
      end
      vectors++;
      if (err != 0) begin
         miscompares++;
         $display("FAIL backpressure_hold: %0d bad cycles of 50, required 0", err);
      end
      recv_byte(8'h78, "bp_b0");
      recv_byte(8'h56, "bp_b1");
      recv_byte(8'h34, "bp_b2");
      recv_byte(8'h12, "bp_b3");
      send_byte(8'h41);
      recv_byte(8'h3F, "bp_held_byte");
   endtask

   task automatic test_reset_mid();
      int hs0 = hs_count;
      mem_ready = 1'b1;
      send_byte(8'h57);
      send_byte(8'h10);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'hEF);
      rx_valid = 1'b1;
      rx_data  = 8'hBE;
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      vectors++;
      if ({rx_ready, tx_valid, mem_valid, mem_write, tx_data, state} !== 16'h0000 ||
          mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_mid_async: rx_ready=%0b tx_valid=%0b mem_valid=%0b state=%0d addr=%08h wdata=%08h, required all 0",
                  rx_ready, tx_valid, mem_valid, state, mem_addr, mem_wdata);
      end
      rx_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      vectors++;
      if (rx_ready !== 1'b1 || state !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_mid_release: rx_ready=%0b state=%0d, required 1 0", rx_ready, state);
      end
      repeat (5) @(negedge clock);
      vectors++;
      if (hs_count !== hs0 || mem_valid !== 1'b0 || tx_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_nowrite: reqs=%0d mem_valid=%0b tx_valid=%0b, required 0 0 0",
                  hs_count - hs0, mem_valid, tx_valid);
      end

      // pending memory request drops asynchronously
      mem_ready = 1'b0;
      send_byte(8'h52);
      send_byte(8'h10);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      vectors++;
      if (mem_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mreq_pending: mem_valid=%0b, required 1", mem_valid);
      end
      #2;
      reset_n = 1'b0;
      #1;
      vectors++;
      if (mem_valid !== 1'b0 || state !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_mreq_drop: mem_valid=%0b state=%0d, required 0 0", mem_valid, state);
      end
      @(negedge clock);
      reset_n   = 1'b1;
      mem_ready = 1'b1;
      @(negedge clock);
      vectors++;
      if (hs_count !== hs0 || rx_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mreq_after: reqs=%0d rx_ready=%0b, required 0 1", hs_count - hs0, rx_ready);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_unknown();
      test_timeout();
      test_backpressure();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // global time bound
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached after %0d vectors", vectors);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/serial_mem_responder.md
SERIAL_MEM_RESPONDER -- requirements
Module: serial_mem_responder

Interface
REQ-001 SHALL take parameter TIMEOUT, default 1_000_000, the number of idle clock cycles allowed between bytes of one command before it is abandoned.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port clock, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port rx_valid, input, 1 bit: incoming host byte present.
REQ-006 SHALL have port rx_data, input, 8 bits: incoming host byte.
REQ-007 SHALL have port rx_ready, output, 1 bit: responder accepts rx_data this cycle.
REQ-008 SHALL have port tx_valid, output, 1 bit: response byte present.
REQ-009 SHALL have port tx_data, output, 8 bits: response byte.
REQ-010 SHALL have port tx_ready, input, 1 bit: downstream transmitter takes tx_data this cycle.
REQ-011 SHALL have port mem_valid, output, 1 bit: memory request pending.
REQ-012 SHALL have port mem_ready, input, 1 bit: memory accepts the request.
REQ-013 SHALL have port mem_write, output, 1 bit: 1 means write, 0 means read.
REQ-014 SHALL have port mem_addr, output, 32 bits: word address.
REQ-015 SHALL have port mem_wdata, output, 32 bits: write data.
REQ-016 SHALL have port mem_rvalid, input, 1 bit: read data return strobe.
REQ-017 SHALL have port mem_rdata, input, 32 bits: read data.
REQ-018 SHALL have port state, output, 4 bits: current FSM state encoding, for LEDs.

Function
REQ-019 SHALL implement the FSM states IDLE=0, ADDR=1, DATA=2, MREQ=3, MWAIT=4, RESP=5.
REQ-020 SHALL consume a byte only on the rx_valid & rx_ready cycle, and SHALL assert rx_ready only in IDLE, ADDR and DATA.
REQ-021 IDLE: on byte 0x57 ('W') or 0x52 ('R'), SHALL latch the opcode, clear the byte index and go to ADDR.
REQ-022 IDLE: on any other byte, SHALL load response 0x3F ('?') with length 1 and go to RESP.
REQ-023 ADDR: SHALL collect 4 bytes LSB first into mem_addr[7:0], [15:8], [23:16] and [31:24].
REQ-024 ADDR: after the 4th byte, SHALL go to DATA for 'W' or to MREQ for 'R'.
REQ-025 DATA: SHALL collect 4 bytes LSB first into mem_wdata, then go to MREQ.
REQ-026 MREQ: SHALL hold mem_valid=1 with mem_addr, mem_wdata and mem_write stable until mem_ready.
REQ-027 On the MREQ handshake cycle: a write SHALL load response 0x2E ('.') with length 1 and go to RESP; a read SHALL go to MWAIT.
REQ-028 mem_rvalid arriving in the same cycle as the read handshake SHALL be captured and SHALL go directly to RESP.
REQ-029 MWAIT: on mem_rvalid, SHALL latch mem_rdata and load a 4-byte response, LSB first, then go to RESP; MWAIT has no timeout.
REQ-030 RESP: SHALL hold tx_valid=1 with tx_data stable until tx_ready.
REQ-031 RESP: each tx handshake SHALL advance to the next byte; after the last byte, tx_valid SHALL be 0 on the following cycle and the FSM SHALL return to IDLE.
REQ-032 mem_valid SHALL be asserted only in MREQ, and tx_valid only in RESP.
REQ-033 Timeout: in ADDR or DATA, a counter SHALL reset on every consumed byte and increment on every other cycle.
REQ-034 Timeout: when the counter reaches TIMEOUT-1 with no byte consumed that cycle, the FSM SHALL return to IDLE silently, discarding the partial command with no response.
REQ-035 A byte consumed in the same cycle the counter reaches TIMEOUT-1 SHALL win: the byte is accepted and the counter cleared.
REQ-036 The counter width SHALL be $clog2(TIMEOUT)+1, and the counter SHALL saturate rather than wrap.
REQ-037 Back-to-back commands SHALL be supported: rx_ready reasserts in the first IDLE cycle after RESP completes.
REQ-038 Bytes arriving outside IDLE, ADDR and DATA SHALL be back-pressured, not dropped.

Reset
REQ-039 While reset_n=0, all state SHALL clear asynchronously: FSM=IDLE, rx_ready=0, tx_valid=0, mem_valid=0, mem_write=0, mem_addr=0, mem_wdata=0, tx_data=0, state=0, and the byte index, timeout counter and response length = 0.
REQ-040 rx_ready SHALL become 1 in the first clock cycle after reset_n deasserts.
REQ-041 Reset asserted mid-command or mid-response SHALL abort immediately with no further tx or mem activity.
REQ-042 A pending mem_valid SHALL drop asynchronously on reset.

Verification
REQ-043 Write: rx 57 10 00 00 00 EF BE AD DE, mem_ready=1 -> one write with mem_addr=0x00000010 and mem_wdata=0xDEADBEEF, then tx 2E.
REQ-044 Read: rx 52 10 00 00 00, mem_rvalid two cycles later with mem_rdata=0x12345678 -> tx 78 56 34 12, then IDLE.
REQ-045 Unknown opcode: rx 41 -> tx 3F; then rx 52 ... is accepted immediately as a new command.
REQ-046 Timeout, TIMEOUT=16: rx 57 10, then 16 idle cycles -> state=0 and no tx; a following rx 52 ... produces a normal read.
REQ-047 Backpressure: tx_ready=0 for 50 cycles during a read response -> tx_data=78 held stable and rx_ready=0 throughout; after release, all 4 bytes are delivered in order.
REQ-048 Reset: reset_n pulsed low during DATA byte 2 -> all outputs 0 asynchronously, no mem write ever issued, rx_ready=1 the cycle after release.
